// File: rtl/calc_pkg.sv
// calc_pkg: shared defaults and reset-time opcode table for calc_op_enc
// Exports: SEL_W_DEF, OP_W_DEF, DEF_TABLE, def_entry()
package calc_pkg;
   localparam int SEL_W_DEF = 3;
   localparam int OP_W_DEF  = 4;
   localparam logic [3:0] DEF_TABLE [8] = '{4'h2, 4'h0, 4'hD, 4'h9, 4'h6, 4'h1, 4'h7, 4'hA};
   // Default geometry uses the fixed table; any other geometry maps entry i to i.
   function automatic logic [31:0] def_entry(int sel_w, int op_w, int i);
      return (sel_w == SEL_W_DEF && op_w == OP_W_DEF) ? 32'(DEF_TABLE[i[2:0]]) : 32'(i);
   endfunction
endpackage

// File: rtl/calc_op_enc_if.sv
// calc_op_enc_if: button/config/opcode bundle for calc_op_enc
// master (encoder): in sel_in, cfg_we, cfg_addr, cfg_data, op_ready; out op_out, op_valid, op_drop
// slave (user): mirror of master
interface calc_op_enc_if import calc_pkg::*; #(
   parameter int SEL_W = SEL_W_DEF,
   parameter int OP_W  = OP_W_DEF
);
   logic [SEL_W-1:0] sel_in;
   logic             cfg_we;
   logic [SEL_W-1:0] cfg_addr;
   logic [OP_W-1:0]  cfg_data;
   logic [OP_W-1:0]  op_out;
   logic             op_valid;
   logic             op_ready;
   logic             op_drop;
   modport master (input sel_in, cfg_we, cfg_addr, cfg_data, op_ready, output op_out, op_valid, op_drop);
   modport slave (output sel_in, cfg_we, cfg_addr, cfg_data, op_ready, input op_out, op_valid, op_drop);
endinterface

// File: rtl/calc_op_enc_sel_debounce.sv
// sel_debounce: 2-flop synchronizer plus debounce of a button selection
// in clk, rst, sel_in (async); out stable (accepted selection, including one accepted this cycle), sel_event (acceptance pulse)
module sel_debounce #(
   parameter int SEL_W     = 3,
   parameter int DB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel_in,
   output logic [SEL_W-1:0] stable,
   output logic             sel_event
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   logic [SEL_W-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, stable_q, stable_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fire;
   always_comb begin
      fire     = cnt_q == CW'(DB_CYCLES);
      s1_d     = sel_in;
      s2_d     = s1_q;
      // candidate always tracks s2; a change shows up as s2 != candidate and restarts the count
      cand_d   = s2_q;
      stable_d = fire ? cand_q : stable_q;
      cnt_d    = (fire || s2_q == stable_q) ? '0 : (s2_q != cand_q) ? CW'(1) : cnt_q + CW'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q     <= '0;
         s2_q     <= '0;
         cand_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cand_q   <= cand_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end
   // exposing the next value lets the table lookup use the new selection in the event cycle
   assign stable    = stable_d;
   assign sel_event = fire;
endmodule

// File: rtl/calc_op_enc.sv
// calc_op_enc: debounced button selection -> programmable opcode with valid/ready output
// in clk, rst; bus (master): sel_in, cfg_we/cfg_addr/cfg_data table write, op_out/op_valid/op_ready handshake, op_drop
module calc_op_enc import calc_pkg::*; #(
   parameter int SEL_W     = SEL_W_DEF,
   parameter int OP_W      = OP_W_DEF,
   parameter int DB_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   calc_op_enc_if.master bus
);
   localparam int N = 2 ** SEL_W;
   logic [SEL_W-1:0] stable;
   logic             ev, load;
   logic [OP_W-1:0]  tbl_q [N];
   logic [OP_W-1:0]  tbl_d [N];
   logic [OP_W-1:0]  op_out_q, op_out_d;
   logic             op_valid_q, op_valid_d, op_drop_q, op_drop_d;
   sel_debounce #(.SEL_W(SEL_W), .DB_CYCLES(DB_CYCLES)) u_db (
      .clk       (clk),
      .rst       (rst),
      .sel_in    (bus.sel_in),
      .stable    (stable),
      .sel_event (ev)
   );
   always_comb begin
      load       = ev & (~op_valid_q | bus.op_ready);
      // lookup reads tbl_q, so a same-cycle write cannot affect the loaded opcode
      op_out_d   = load ? tbl_q[stable] : op_out_q;
      op_valid_d = load | (op_valid_q & ~bus.op_ready);
      op_drop_d  = ev & op_valid_q & ~bus.op_ready;
      for (int i = 0; i < N; i++) tbl_d[i] = (bus.cfg_we && bus.cfg_addr == SEL_W'(i)) ? bus.cfg_data : tbl_q[i];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         op_out_q   <= '0;
         op_valid_q <= 1'b0;
         op_drop_q  <= 1'b0;
         for (int i = 0; i < N; i++) tbl_q[i] <= OP_W'(def_entry(SEL_W, OP_W, i));
      end else begin
         op_out_q   <= op_out_d;
         op_valid_q <= op_valid_d;
         op_drop_q  <= op_drop_d;
         tbl_q      <= tbl_d;
      end
   end
   assign bus.op_out   = op_out_q;
   assign bus.op_valid = op_valid_q;
   assign bus.op_drop  = op_drop_q;
endmodule

// File: tb/tb_calc_op_enc.sv
// tb_calc_op_enc: scoreboard bench for calc_op_enc with directed vectors
module tb_calc_op_enc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   calc_op_enc_if #(.SEL_W(3), .OP_W(4)) bus ();
   calc_op_enc #(.SEL_W(3), .OP_W(4), .DB_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int failures = 0;
   int valid_cycles = 0;
   int drop_cnt = 0;
   logic [3:0] sb [$];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   // monitor: every accepted opcode is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.op_valid) valid_cycles++;
         if (bus.op_drop) drop_cnt++;
         if (bus.op_valid && bus.op_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_op actual=%0h expected=none t=%0t", bus.op_out, $time);
            end else chk("op_out", 32'(bus.op_out), 32'(sb.pop_front()));
         end
      end
   end
   int v0, d0;
   initial begin
      rst = 1'b1;
      bus.sel_in = '0;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.op_ready = 1'b1;
      step(2);
      chk("rst_valid", 32'(bus.op_valid), 0);
      chk("rst_out", 32'(bus.op_out), 0);
      chk("rst_drop", 32'(bus.op_drop), 0);
      rst = 1'b0;
      step(12);
      chk("sel0_no_event", valid_cycles, 0);
      // latency: new selection before edge 1 -> valid after edge 7, for one cycle
      bus.sel_in = 3'b010;
      sb.push_back(4'hD);
      step(6);
      chk("lat_e6_valid", 32'(bus.op_valid), 0);
      step(1);
      chk("lat_e7_valid", 32'(bus.op_valid), 1);
      chk("lat_e7_out", 32'(bus.op_out), 32'hD);
      step(1);
      chk("lat_e8_valid", 32'(bus.op_valid), 0);
      step(4);
      chk("lat_one_cycle", valid_cycles, 1);
      // default table sweep
      v0 = valid_cycles;
      for (int i = 0; i < 8; i++) begin
         bus.sel_in = 3'(i);
         case (i)
            0: sb.push_back(4'h2);
            1: sb.push_back(4'h0);
            2: sb.push_back(4'hD);
            3: sb.push_back(4'h9);
            4: sb.push_back(4'h6);
            5: sb.push_back(4'h1);
            6: sb.push_back(4'h7);
            default: sb.push_back(4'hA);
         endcase
         step(10);
      end
      chk("sweep_drained", sb.size(), 0);
      chk("sweep_count", valid_cycles - v0, 8);
      // glitch shorter than the debounce window
      bus.sel_in = 3'b000;
      sb.push_back(4'h2);
      step(10);
      v0 = valid_cycles;
      d0 = drop_cnt;
      bus.sel_in = 3'b100;
      step(2);
      bus.sel_in = 3'b000;
      step(12);
      chk("glitch_valid", valid_cycles - v0, 0);
      chk("glitch_drop", drop_cnt - d0, 0);
      chk("glitch_stable", 32'(dut.u_db.stable_q), 0);
      // backpressure
      bus.op_ready = 1'b0;
      bus.sel_in = 3'b011;
      sb.push_back(4'h9);
      step(10);
      chk("bp_valid", 32'(bus.op_valid), 1);
      chk("bp_out", 32'(bus.op_out), 32'h9);
      d0 = drop_cnt;
      bus.sel_in = 3'b101;
      step(10);
      chk("bp_drop_pulse", drop_cnt - d0, 1);
      chk("bp_out_held", 32'(bus.op_out), 32'h9);
      chk("bp_valid_held", 32'(bus.op_valid), 1);
      bus.op_ready = 1'b1;
      step(1);
      chk("bp_clear", 32'(bus.op_valid), 0);
      chk("bp_retain", 32'(bus.op_out), 32'h9);
      // table writes
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'b111;
      bus.cfg_data = 4'h5;
      step(1);
      bus.cfg_we = 1'b0;
      bus.op_ready = 1'b0;
      bus.sel_in = 3'b111;
      sb.push_back(4'h5);
      step(10);
      chk("wr_out", 32'(bus.op_out), 32'h5);
      bus.cfg_we = 1'b1;
      bus.cfg_data = 4'h3;
      step(1);
      bus.cfg_we = 1'b0;
      step(2);
      chk("wr_no_alter", 32'(bus.op_out), 32'h5);
      bus.op_ready = 1'b1;
      step(1);
      chk("wr_clear", 32'(bus.op_valid), 0);
      bus.sel_in = 3'b000;
      sb.push_back(4'h2);
      step(10);
      bus.sel_in = 3'b111;
      sb.push_back(4'h3);
      step(10);
      chk("wr_drained", sb.size(), 0);
      // reset mid-debounce with a pending opcode
      bus.op_ready = 1'b0;
      bus.sel_in = 3'b011;
      sb.push_back(4'h9);
      step(10);
      chk("pre_rst_valid", 32'(bus.op_valid), 1);
      bus.sel_in = 3'b110;
      step(3);
      rst = 1'b1;
      step(1);
      chk("mid_rst_valid", 32'(bus.op_valid), 0);
      chk("mid_rst_out", 32'(bus.op_out), 0);
      chk("mid_rst_drop", 32'(bus.op_drop), 0);
      sb.delete();
      rst = 1'b0;
      bus.op_ready = 1'b1;
      bus.sel_in = 3'b111;
      sb.push_back(4'hA);
      step(10);
      chk("final_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
